clken_dds_gen: RTL
==================

Name: clken_dds_gen

Overview:
- Multi-channel fractional clock-enable generator built on phase accumulators (DDS). Runs in the single system clock domain.
- Each channel emits one-cycle `tick` strobes at an average rate of f_clk × inc / 2^ACC_W. Downstream logic (pixel timing, audio, peripheral pacing) uses these strobes as clock enables instead of extra MMCM outputs.
- Supports runtime retuning per channel. New increments are applied glitch-free at the channel's next wrap boundary.
- Per-channel and aggregate lock status indicate when each rate has settled.

Parameters:
- CHANNELS, 2, number of independent tick channels (1-8)
- ACC_W, 32, phase accumulator width in bits (8-48)
- INC_INIT, 32'h4083_126F, increment loaded into every channel at reset (25.2 MHz from 100 MHz at ACC_W=32)
- SETTLE_TICKS, 16, ticks after an applied config before `locked` asserts (1-255)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- en  in  1  global advance enable; 0 freezes all accumulators
- cfg_valid  in  1  config request
- cfg_ready  out  1  config can be accepted
- cfg_chan  in  max(1,$clog2(CHANNELS))  target channel
- cfg_inc  in  ACC_W  new increment; 0 stops the channel
- tick  out  CHANNELS  per-channel clock-enable strobe, registered
- locked  out  CHANNELS  per-channel settled flag, registered
- all_locked  out  1  AND of `locked` over channels with nonzero active inc; 0 if no channel is active

Behaviour:
- Reset (rst=0 at a clk edge):
  - Each channel: acc=0, inc=INC_INIT, no pending, lock_cnt=0.
  - Outputs: tick=0, locked=0, all_locked=0, cfg_ready=1.
  - Channel state is RUN if INC_INIT≠0, else IDLE.
  - Asserting reset mid-operation drops any pending config and restarts from these values.
- Channel states:
  - IDLE: inc=0. No ticks, locked=0.
  - RUN: accumulating, lock_cnt counting.
  - LOCK: accumulating, locked=1.
  - A pending flag is orthogonal to these states.
- Accumulation, each edge with en=1 in RUN or LOCK:
  - {carry, acc} <= acc + inc, computed at ACC_W+1 bits. Wrap-around is modulo 2^ACC_W; the residue is kept.
  - tick <= carry. Tick is high for exactly one cycle following the edge on which the carry occurred.
  - In IDLE, or when en=0, tick <= 0.
- en=0: acc, lock_cnt and pending hold; tick=0; locked holds.
- Lock counting:
  - In RUN, each tick increments lock_cnt.
  - On the edge where lock_cnt reaches SETTLE_TICKS, the channel moves to LOCK and locked=1 (registered, same edge as the final tick is registered).
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready at an edge.
  - cfg_ready = 1 when no channel has a pending config.
  - cfg_chan ≥ CHANNELS: transfer accepted and ignored.
- Applying config to a target in IDLE:
  - Applied on the transfer edge: inc=cfg_inc, acc=0, lock_cnt=0.
  - Next state is RUN, or stays IDLE if cfg_inc=0.
- Applying config to a target in RUN or LOCK:
  - Stored as pending; cfg_ready falls the next cycle.
  - Applied on the first later edge where the channel's carry occurs. That tick is still emitted with the old rate.
  - On apply: inc=pending value, acc keeps the post-wrap residue (or is cleared if the new inc=0 → IDLE), lock_cnt=0, locked=0 from that edge, state RUN.
  - Pending is cleared; cfg_ready returns to 1 the next cycle.
- Simultaneous events:
  - A transfer on the same edge as the target's carry is not applied on that carry; it waits for the next one.
  - A new inc equal to the current inc still resets lock.
- all_locked is registered from the next-state values: it updates on the same edge as `locked`.
- Latency:
  - cfg→apply for an IDLE target: 1 edge.
  - For a running target: up to 2^ACC_W/inc enabled edges.

Test Plan:
1. ACC_W=8, INC_INIT=64, SETTLE_TICKS=4, en=1 after reset release → tick[0] first high after the 4th edge, then exactly every 4 cycles; locked[0] rises on the edge registering the 4th tick; all_locked follows it.
2. ACC_W=8, INC_INIT=96 → tick pattern period of 8 cycles containing exactly 3 ticks (acc 96,192,32c,128,224,64c,160,0c); long-run count over 800 cycles = 300.
3. Running at inc=64, write cfg_inc=128 to ch0 mid-period → cfg_ready low until the next wrap; the old-rate tick is still emitted; then ticks every 2 cycles; locked drops on the apply edge and returns after 4 new ticks.
4. Write cfg_inc=0 to a running channel, then write 32 to the same channel → first write applies at the wrap (no further ticks, locked=0, all_locked=0); second write applies on the next edge with acc=0, ticks every 8 cycles.
5. Hold en=0 for 10 cycles mid-period → no ticks, acc frozen; resuming keeps the exact phase (next tick at the remaining count); pending config applies only after resume.
6. Assert rst for one edge while a config is pending and locked=1 → all outputs return to reset values, pending discarded, cfg_ready=1, tick cadence restarts from acc=0 at INC_INIT.

Source files
------------

// File: rtl/clken_dds_if.sv
// Configuration request channel for clken_dds_gen: retarget one channel's phase increment.
interface clken_dds_if #(
  parameter int CHANNELS = 2,
  parameter int ACC_W    = 32
);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CW-1:0]    cfg_chan;
  logic [ACC_W-1:0] cfg_inc;

  modport master (output cfg_valid, cfg_chan, cfg_inc, input cfg_ready);
  modport slave  (input cfg_valid, cfg_chan, cfg_inc, output cfg_ready);
endinterface

// File: rtl/clken_dds_gen.sv
// Multi-channel DDS clock-enable generator: per-channel phase accumulators emit one-cycle
// ticks at f_clk*inc/2^ACC_W, with retuning applied at the channel's next wrap.
module clken_dds_chan #(
  parameter int             ACC_W        = 32,
  parameter logic [ACC_W-1:0] INC_INIT   = ACC_W'(32'h4083_126F),
  parameter int             SETTLE_TICKS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [ACC_W-1:0] wr_inc,
  output logic             tick,
  output logic             locked,
  output logic             pend,
  output logic             act_d,
  output logic             lock_d
);
  typedef enum logic [1:0] {IDLE, RUN, LOCK} st_t;

  st_t              st;
  logic [ACC_W-1:0] acc, inc, pend_inc;
  logic [7:0]       cnt;
  logic [ACC_W:0]   sum;
  logic             carry, adv, apply, hit;

  // act_d/lock_d are the next-state view, so the aggregate flag lands on the same edge as locked
  always_comb begin
    sum    = {1'b0, acc} + {1'b0, inc};
    carry  = sum[ACC_W];
    adv    = en && (st != IDLE);
    apply  = adv && carry && pend;
    hit    = adv && carry && !pend && (st == RUN) && (cnt == 8'(SETTLE_TICKS - 1));
    act_d  = (st != IDLE);
    lock_d = (st == LOCK);
    if (st == IDLE && wr) begin
      act_d  = |wr_inc;
      lock_d = 1'b0;
    end else if (apply) begin
      act_d  = |pend_inc;
      lock_d = 1'b0;
    end else if (hit) begin
      lock_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc      <= '0;
      inc      <= INC_INIT;
      pend     <= 1'b0;
      pend_inc <= '0;
      cnt      <= '0;
      tick     <= 1'b0;
      locked   <= 1'b0;
      st       <= (INC_INIT != '0) ? RUN : IDLE;
    end else begin
      locked <= lock_d;
      tick   <= adv && carry;
      case (st)
        IDLE: begin
          if (wr) begin
            inc <= wr_inc;
            acc <= '0;
            cnt <= '0;
            st  <= (wr_inc != '0) ? RUN : IDLE;
          end
        end
        default: begin
          if (en) begin
            acc <= sum[ACC_W-1:0];
            if (apply) begin
              // the wrap tick belongs to the old rate; the residue carries into the new one
              inc  <= pend_inc;
              cnt  <= '0;
              pend <= 1'b0;
              if (pend_inc == '0) begin
                st  <= IDLE;
                acc <= '0;
              end else begin
                st <= RUN;
              end
            end else if (carry && st == RUN) begin
              cnt <= cnt + 8'd1;
              if (hit) st <= LOCK;
            end
          end
          // a request landing on a wrap edge waits for the following wrap
          if (wr) begin
            pend     <= 1'b1;
            pend_inc <= wr_inc;
          end
        end
      endcase
    end
  end
endmodule

module clken_dds_gen #(
  parameter int               CHANNELS     = 2,
  parameter int               ACC_W        = 32,
  parameter logic [ACC_W-1:0] INC_INIT     = ACC_W'(32'h4083_126F),
  parameter int               SETTLE_TICKS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  clken_dds_if.slave          cfg,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] locked,
  output logic                all_locked
);
  logic [CHANNELS-1:0] pend, act_d, lock_d;
  logic                xfer;

  assign cfg.cfg_ready = ~|pend;
  assign xfer          = cfg.cfg_valid && cfg.cfg_ready;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    clken_dds_chan #(
      .ACC_W(ACC_W), .INC_INIT(INC_INIT), .SETTLE_TICKS(SETTLE_TICKS)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .wr     (xfer && (32'(cfg.cfg_chan) == i)),
      .wr_inc (cfg.cfg_inc),
      .tick   (tick[i]),
      .locked (locked[i]),
      .pend   (pend[i]),
      .act_d  (act_d[i]),
      .lock_d (lock_d[i])
    );
  end

  // stopped channels are excluded; nothing active means not locked
  always_ff @(posedge clk) begin
    if (!rst) all_locked <= 1'b0;
    else      all_locked <= (|act_d) && (&(lock_d | ~act_d));
  end
endmodule
